// File: rtl/gt_bringup_pkg.sv
// Shared encodings for the GT link bring-up controller: global and lane FSM states,
// LED display modes and small elaboration-time helpers.
package gt_bringup_pkg;

  typedef enum logic [1:0] {
    G_PLL    = 2'd0,
    G_GTRST  = 2'd1,
    G_TXWAIT = 2'd2,
    G_RUN    = 2'd3
  } gstate_t;

  typedef enum logic [2:0] {
    C_OFF   = 3'd0,
    C_WAIT  = 3'd1,
    C_RXRST = 3'd2,
    C_UP    = 3'd3,
    C_FAULT = 3'd4
  } lstate_t;

  typedef enum logic [1:0] {
    LED_OFF  = 2'd0,
    LED_SLOW = 2'd1,
    LED_ON   = 2'd2,
    LED_FAST = 2'd3
  } led_mode_t;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2_safe(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic led_mode_t lane_led_mode(input lstate_t s);
    led_mode_t m;
    case (s)
      C_WAIT, C_RXRST: m = LED_SLOW;
      C_UP:            m = LED_ON;
      C_FAULT:         m = LED_FAST;
      default:         m = LED_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/gt_bringup_lane.sv
// Per-lane RX bring-up FSM: block-lock wait with timeout, RX datapath reset retries,
// fault latch, link-down counting and the lane status LED.
module gt_bringup_lane
  import gt_bringup_pkg::*;
#(
  parameter int RESET_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1250000,
  parameter int RETRY_LIMIT    = 7,
  parameter int CNT_W          = 8,
  parameter int TMR_W          = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             rx_done,
  input  logic             block_lock,
  input  logic             high_ber,
  input  logic             npres,
  input  logic             los,
  input  logic             led_slow,
  input  logic             led_fast,
  output logic             rx_datapath_reset,
  output logic             tx_disable,
  output logic             link_up,
  output logic             led,
  output logic             lane_fault,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] linkdown_count
);

  lstate_t            state, state_next;
  logic [TMR_W-1:0]   timer, timer_next;
  logic [CNT_W-1:0]   retry_next, linkdown_next;
  logic               npres_prev;
  logic               npres_rise;
  logic               led_next;

  assign npres_rise = npres & ~npres_prev;

  always_comb begin
    state_next    = state;
    timer_next    = timer;
    retry_next    = retry_count;
    linkdown_next = linkdown_count;
    case (state)
      C_OFF: begin
        timer_next = '0;
        if (run && !npres && !los) state_next = C_WAIT;
      end
      C_WAIT: begin
        // success is tested first so it wins over a same-cycle timeout
        if (rx_done && block_lock && !high_ber) begin
          state_next = C_UP;
          timer_next = '0;
          retry_next = '0;
        end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_next = C_RXRST;
          timer_next = '0;
          retry_next = retry_count + CNT_W'(1);
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      C_RXRST: begin
        if (timer == TMR_W'(RESET_CYCLES - 1)) begin
          timer_next = '0;
          state_next = (retry_count == CNT_W'(RETRY_LIMIT)) ? C_FAULT : C_WAIT;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      C_UP: begin
        if (!block_lock || high_ber) begin
          state_next = C_WAIT;
          timer_next = '0;
          if (linkdown_count != '1) linkdown_next = linkdown_count + CNT_W'(1);
        end
      end
      C_FAULT: begin
        if (npres_rise) begin
          state_next = C_OFF;
          retry_next = '0;
        end
      end
      default: state_next = C_OFF;
    endcase

    // Losing the global run state or the optical path beats any lane-local event.
    if (!run || ((npres || los) && state != C_FAULT)) begin
      state_next    = C_OFF;
      timer_next    = '0;
      retry_next    = (state == C_FAULT) ? '0 : retry_count;
      linkdown_next = linkdown_count;
    end
  end

  always_comb begin
    led_next = 1'b0;
    case (lane_led_mode(state_next))
      LED_SLOW: led_next = led_slow;
      LED_ON:   led_next = 1'b1;
      LED_FAST: led_next = led_fast;
      default:  led_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= C_OFF;
      timer             <= '0;
      retry_count       <= '0;
      linkdown_count    <= '0;
      npres_prev        <= 1'b1;
      rx_datapath_reset <= 1'b0;
      tx_disable        <= 1'b1;
      link_up           <= 1'b0;
      led               <= 1'b0;
      lane_fault        <= 1'b0;
    end else begin
      state             <= state_next;
      timer             <= timer_next;
      retry_count       <= retry_next;
      linkdown_count    <= linkdown_next;
      npres_prev        <= npres;
      rx_datapath_reset <= (state_next == C_RXRST);
      tx_disable        <= (state_next == C_FAULT) || ((state_next == C_OFF) && npres);
      link_up           <= (state_next == C_UP);
      led               <= led_next;
      lane_fault        <= (state_next == C_FAULT);
    end
  end

endmodule

// File: rtl/gt_link_bringup_ctrl.sv
// Top of the SFP+/GT bring-up controller: input synchronisers, the global
// MMCM-lock / GT-reset / TX-done sequencer, the shared LED divider and the lane FSMs.
module gt_link_bringup_ctrl
  import gt_bringup_pkg::*;
#(
  parameter int CH_COUNT       = 2,
  parameter int SYNC_STAGES    = 4,
  parameter int RESET_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1250000,
  parameter int RETRY_LIMIT    = 7,
  parameter int CNT_W          = 8,
  parameter int LED_DIV_LOG2   = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pll_locked,
  input  logic                      gt_tx_done,
  input  logic                      gt_rx_done,
  input  logic [CH_COUNT-1:0]       rx_block_lock,
  input  logic [CH_COUNT-1:0]       rx_high_ber,
  input  logic [CH_COUNT-1:0]       sfp_npres,
  input  logic [CH_COUNT-1:0]       sfp_los,
  output logic                      gt_reset_all,
  output logic [CH_COUNT-1:0]       rx_datapath_reset,
  output logic [CH_COUNT-1:0]       sfp_tx_disable,
  output logic [CH_COUNT-1:0]       link_up,
  output logic [CH_COUNT-1:0]       led,
  output logic [CH_COUNT-1:0]       lane_fault,
  output logic [CH_COUNT*CNT_W-1:0] retry_count,
  output logic [CH_COUNT*CNT_W-1:0] linkdown_count
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
  localparam int TMR_W   = clog2_safe(TMR_MAX);
  localparam int N_IN    = 3 + 4 * CH_COUNT;
  // npres and los sit in the top bits and idle "absent / no light" during reset
  localparam logic [N_IN-1:0] SYNC_INIT = {{(2 * CH_COUNT){1'b1}}, {(2 * CH_COUNT + 3){1'b0}}};

  logic [N_IN-1:0]                   async_in;
  logic [SYNC_STAGES-1:0][N_IN-1:0]  sync_reg;
  logic [N_IN-1:0]                   sync_out;

  logic                pll_s, tx_done_s, rx_done_s;
  logic [CH_COUNT-1:0] block_lock_s, high_ber_s, npres_s, los_s;

  gstate_t             g_state, g_next;
  logic [TMR_W-1:0]    g_timer, g_timer_next;
  logic                run;
  logic [LED_DIV_LOG2-1:0] led_cnt;

  assign async_in = {sfp_los, sfp_npres, rx_high_ber, rx_block_lock, gt_rx_done, gt_tx_done, pll_locked};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= {SYNC_STAGES{SYNC_INIT}};
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
  end

  assign sync_out     = sync_reg[SYNC_STAGES-1];
  assign pll_s        = sync_out[0];
  assign tx_done_s    = sync_out[1];
  assign rx_done_s    = sync_out[2];
  assign block_lock_s = sync_out[3 +: CH_COUNT];
  assign high_ber_s   = sync_out[3 + CH_COUNT +: CH_COUNT];
  assign npres_s      = sync_out[3 + 2 * CH_COUNT +: CH_COUNT];
  assign los_s        = sync_out[3 + 3 * CH_COUNT +: CH_COUNT];

  always_comb begin
    g_next       = g_state;
    g_timer_next = g_timer;
    case (g_state)
      G_PLL: begin
        g_timer_next = '0;
        if (pll_s) g_next = G_GTRST;
      end
      G_GTRST: begin
        if (g_timer == TMR_W'(RESET_CYCLES - 1)) begin
          g_next       = G_TXWAIT;
          g_timer_next = '0;
        end else begin
          g_timer_next = g_timer + TMR_W'(1);
        end
      end
      G_TXWAIT: begin
        if (tx_done_s) begin
          g_next       = G_RUN;
          g_timer_next = '0;
        end else if (g_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          g_next       = G_GTRST;
          g_timer_next = '0;
        end else begin
          g_timer_next = g_timer + TMR_W'(1);
        end
      end
      G_RUN:   g_timer_next = '0;
      default: g_next = G_PLL;
    endcase
    if (!pll_s) begin
      g_next       = G_PLL;
      g_timer_next = '0;
    end
  end

  // Lanes follow the next global state so leaving G_RUN drops them on the same edge.
  assign run = (g_next == G_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_state      <= G_PLL;
      g_timer      <= '0;
      gt_reset_all <= 1'b1;
      led_cnt      <= '0;
    end else begin
      g_state      <= g_next;
      g_timer      <= g_timer_next;
      gt_reset_all <= (g_next == G_PLL) || (g_next == G_GTRST);
      led_cnt      <= led_cnt + LED_DIV_LOG2'(1);
    end
  end

  for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_lane
    gt_bringup_lane #(
      .RESET_CYCLES   (RESET_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .RETRY_LIMIT    (RETRY_LIMIT),
      .CNT_W          (CNT_W),
      .TMR_W          (TMR_W)
    ) u_lane (
      .clk               (clk),
      .rst               (rst),
      .run               (run),
      .rx_done           (rx_done_s),
      .block_lock        (block_lock_s[gi]),
      .high_ber          (high_ber_s[gi]),
      .npres             (npres_s[gi]),
      .los               (los_s[gi]),
      .led_slow          (led_cnt[LED_DIV_LOG2-1]),
      .led_fast          (led_cnt[LED_DIV_LOG2-3]),
      .rx_datapath_reset (rx_datapath_reset[gi]),
      .tx_disable        (sfp_tx_disable[gi]),
      .link_up           (link_up[gi]),
      .led               (led[gi]),
      .lane_fault        (lane_fault[gi]),
      .retry_count       (retry_count[gi*CNT_W +: CNT_W]),
      .linkdown_count    (linkdown_count[gi*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_gt_link_bringup_ctrl.sv
// Directed bench for gt_link_bringup_ctrl with short timers; expected values are hand-derived
// from the synchroniser depth (2), reset width (8), timeout (100) and retry limit (3).
module tb_gt_link_bringup_ctrl;

  localparam int CH = 2;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            pll_locked, gt_tx_done, gt_rx_done;
  logic [CH-1:0]   rx_block_lock, rx_high_ber, sfp_npres, sfp_los;
  logic            gt_reset_all;
  logic [CH-1:0]   rx_datapath_reset, sfp_tx_disable, link_up, led, lane_fault;
  logic [CH*CW-1:0] retry_count, linkdown_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gt_link_bringup_ctrl #(
    .CH_COUNT(CH), .SYNC_STAGES(2), .RESET_CYCLES(8), .TIMEOUT_CYCLES(100),
    .RETRY_LIMIT(3), .CNT_W(CW), .LED_DIV_LOG2(24)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .gt_tx_done(gt_tx_done),
    .gt_rx_done(gt_rx_done), .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
    .sfp_npres(sfp_npres), .sfp_los(sfp_los), .gt_reset_all(gt_reset_all),
    .rx_datapath_reset(rx_datapath_reset), .sfp_tx_disable(sfp_tx_disable),
    .link_up(link_up), .led(led), .lane_fault(lane_fault),
    .retry_count(retry_count), .linkdown_count(linkdown_count)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_sig(input int which);
    return (which == 0) ? gt_reset_all : rx_datapath_reset[0];
  endfunction

  // Number of consecutive samples (current one included) at level lvl, bounded by limit.
  task automatic run_len(input int which, input logic lvl, input int limit, output int n);
    n = 0;
    while (n < limit && sel_sig(which) == lvl) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; pll_locked = 1'b1; gt_tx_done = 1'b0; gt_rx_done = 1'b1;
    rx_block_lock = 2'b11; rx_high_ber = 2'b00; sfp_npres = 2'b10; sfp_los = 2'b00;
    repeat (3) tick();

    check("rst_gt_reset_all", 32'(gt_reset_all), 1);
    check("rst_rx_reset", 32'(rx_datapath_reset), 0);
    check("rst_tx_disable", 32'(sfp_tx_disable), 3);
    check("rst_link_led_fault", 32'({link_up, led, lane_fault}), 0);
    check("rst_counters", 32'({retry_count, linkdown_count}), 0);

    // 1: 1 sample before the first edge + 2 sync + 8 GTRST cycles
    rst = 1'b0;
    run_len(0, 1'b1, 50, n);
    check("pwrup_reset_high", n, 11);

    // 2: TX done never arrives -> 100 low / 8 high cycles repeating, lanes stay off
    run_len(0, 1'b0, 200, n);
    check("txwait_low", n, 100);
    run_len(0, 1'b1, 50, n);
    check("gtrst_retry_high", n, 8);
    run_len(0, 1'b0, 200, n);
    check("txwait_low_again", n, 100);
    run_len(0, 1'b1, 50, n);
    check("gtrst_retry_high_again", n, 8);
    check("txwait_lanes_down", 32'(link_up), 0);
    check("txwait_no_rxrst", 32'(rx_datapath_reset), 0);
    check("txwait_tx_disable", 32'(sfp_tx_disable), 2);

    // 3: run, lane0 locks 40 cycles after entering WAIT
    gt_tx_done = 1'b1; rx_block_lock = 2'b00;
    repeat (43) tick();
    rx_block_lock = 2'b01;
    n = 0;
    while (n < 10 && !link_up[0]) begin tick(); n++; end
    check("lock_latency", n, 3);
    check("up_link_up", 32'(link_up), 1);
    check("up_led", 32'(led), 1);
    check("up_retry0", 32'(retry_count[CW-1:0]), 0);
    check("up_tx_disable", 32'(sfp_tx_disable), 2);

    // 5: link-down counting and saturation
    for (int k = 1; k <= 300; k++) begin
      rx_block_lock[0] = 1'b0;
      n = 0;
      while (n < 5 && link_up[0]) begin tick(); n++; end
      if (k == 1) check("down_latency", n, 3);
      repeat (5 - n) tick();
      rx_block_lock[0] = 1'b1;
      n = 0;
      while (n < 20 && !link_up[0]) begin tick(); n++; end
      if (k == 1 || k == 300) check("relock_latency", n, 3);
      if (k == 1)   check("linkdown_1", 32'(linkdown_count[CW-1:0]), 1);
      if (k == 254) check("linkdown_254", 32'(linkdown_count[CW-1:0]), 254);
      if (k == 300) check("linkdown_sat", 32'(linkdown_count[CW-1:0]), 255);
    end
    check("linkdown_lane1", 32'(linkdown_count[2*CW-1:CW]), 0);

    // 4: lane0 never locks -> three RX reset pulses then FAULT
    rx_block_lock[0] = 1'b0;
    for (int p = 0; p < 3; p++) begin
      run_len(1, 1'b0, 300, n);
      if (p > 0) check("rx_wait_gap", n, 100);
      run_len(1, 1'b1, 50, n);
      check("rx_reset_width", n, 8);
    end
    check("fault_flag", 32'(lane_fault), 1);
    check("fault_tx_disable", 32'(sfp_tx_disable), 3);
    check("fault_retry", 32'(retry_count[CW-1:0]), 3);
    check("fault_led", 32'(led), 0);
    repeat (150) tick();
    check("fault_sticky", 32'(lane_fault), 1);
    check("fault_no_rxrst", 32'(rx_datapath_reset), 0);
    sfp_npres[0] = 1'b1;
    n = 0;
    while (n < 10 && lane_fault[0]) begin tick(); n++; end
    check("fault_exit_latency", n, 3);
    check("fault_exit_retry", 32'(retry_count[CW-1:0]), 0);
    check("off_tx_disable", 32'(sfp_tx_disable), 3);
    sfp_npres[0] = 1'b0;
    repeat (3) tick();
    check("reinsert_tx_enable", 32'(sfp_tx_disable), 2);

    // 6b: los reaches the lane on the exact cycle its WAIT timer expires
    run_len(1, 1'b0, 300, n);
    check("reinsert_wait", n, 100);
    check("retry_after_one", 32'(retry_count[CW-1:0]), 1);
    repeat (105) tick();
    sfp_los[0] = 1'b1;
    repeat (3) tick();
    check("los_vs_timeout_rxrst", 32'(rx_datapath_reset), 0);
    check("los_vs_timeout_retry", 32'(retry_count[CW-1:0]), 1);
    repeat (10) tick();
    check("los_stays_off", 32'(rx_datapath_reset), 0);

    // 6: both lanes up, then MMCM lock lost
    sfp_los = 2'b00; sfp_npres = 2'b00; rx_block_lock = 2'b11;
    n = 0;
    while (n < 20 && link_up != 2'b11) begin tick(); n++; end
    check("both_up", 32'(link_up), 3);
    check("up_clears_retry", 32'(retry_count), 0);
    pll_locked = 1'b0;
    n = 0;
    while (n < 10 && !(gt_reset_all && link_up == 2'b00)) begin tick(); n++; end
    check("pll_loss_latency", n, 3);
    check("pll_loss_link", 32'(link_up), 0);
    check("pll_loss_reset_all", 32'(gt_reset_all), 1);
    check("pll_loss_tx_disable", 32'(sfp_tx_disable), 0);
    check("pll_loss_linkdown", 32'(linkdown_count), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
